forwarding_control_unit: RTL and testbench

- Generates the forwarding select codes (`o_corto_register_A` / `o_corto_register_B`) that drive the EX-stage ALU operand muxes of the 5-stage MIPS pipeline.
- Keeps an internal shadow of destination-register / write-enable / load flags for the ID/EX, EX/MEM and MEM/WB stages.
- Detects load-use hazards and requests a one-cycle stall plus bubble.
- Sits beside the ID/EX pipeline register; its select outputs are registered so they are valid during the EX stage.

---
 rtl/forwarding_control_unit_pkg.sv | 14 +
 rtl/forwarding_control_unit_if.sv | 36 +++
 rtl/forwarding_control_unit_operand_select.sv | 26 ++
 rtl/forwarding_control_unit.sv | 93 +++++++++
 tb/tb_forwarding_control_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/forwarding_control_unit_pkg.sv
// Shared pipeline constants for the EX-stage forwarding unit.
// Holds the forwarding select codes and the default register-specifier widths.
package forwarding_control_unit_pkg;

   localparam int DEFAULT_BITS_REGS          = 5;
   localparam int DEFAULT_BITS_CORTOCIRCUITO = 3;

   localparam logic [2:0] FWD_IDEX  = 3'b000;
   localparam logic [2:0] FWD_EXMEM = 3'b001;
   localparam logic [2:0] FWD_MEMWB = 3'b010;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forwarding_control_unit_if.sv
// Connection between the ID stage / pipeline control and the forwarding unit.
// The shadow_* vectors expose each slot as {dest, regwrite, memread} for observation.
interface forwarding_control_unit_if
   import forwarding_control_unit_pkg::*;
#(
   parameter int BITS_REGS          = DEFAULT_BITS_REGS,
   parameter int BITS_CORTOCIRCUITO = DEFAULT_BITS_CORTOCIRCUITO
);

   logic                          i_pipe_en;
   logic [BITS_REGS-1:0]          i_id_rs;
   logic [BITS_REGS-1:0]          i_id_rt;
   logic [BITS_REGS-1:0]          i_id_dest;
   logic                          i_id_regwrite;
   logic                          i_id_memread;
   logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A;
   logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B;
   logic                          o_stall;
   logic                          o_flush_idex;
   logic [BITS_REGS+1:0]          shadow_ex;
   logic [BITS_REGS+1:0]          shadow_mem;
   logic [BITS_REGS+1:0]          shadow_wb;

   modport master (
      output i_pipe_en, i_id_rs, i_id_rt, i_id_dest, i_id_regwrite, i_id_memread,
      input  o_corto_register_A, o_corto_register_B, o_stall, o_flush_idex,
      input  shadow_ex, shadow_mem, shadow_wb
   );

   modport slave (
      input  i_pipe_en, i_id_rs, i_id_rt, i_id_dest, i_id_regwrite, i_id_memread,
      output o_corto_register_A, o_corto_register_B, o_stall, o_flush_idex,
      output shadow_ex, shadow_mem, shadow_wb
   );

endinterface

// File: rtl/forwarding_control_unit_operand_select.sv
// Compare/priority block choosing where one ALU operand should be sourced from.
// A producer in EX (about to be in MEM) wins over one in MEM; register $0 never forwards.
module forwarding_operand_select
   import forwarding_control_unit_pkg::*;
#(
   parameter int BITS_REGS          = DEFAULT_BITS_REGS,
   parameter int BITS_CORTOCIRCUITO = DEFAULT_BITS_CORTOCIRCUITO
) (
   input  logic [BITS_REGS-1:0]          operand,
   input  logic [BITS_REGS-1:0]          ex_dest,
   input  logic                          ex_regwrite,
   input  logic [BITS_REGS-1:0]          mem_dest,
   input  logic                          mem_regwrite,
   output logic [BITS_CORTOCIRCUITO-1:0] sel
);

   always_comb begin
      sel = BITS_CORTOCIRCUITO'(FWD_IDEX);
      if (ex_regwrite && (ex_dest != '0) && (ex_dest == operand)) begin
         sel = BITS_CORTOCIRCUITO'(FWD_EXMEM);
      end else if (mem_regwrite && (mem_dest != '0) && (mem_dest == operand)) begin
         sel = BITS_CORTOCIRCUITO'(FWD_MEMWB);
      end
   end

endmodule

// File: rtl/forwarding_control_unit.sv
// Forwarding and load-use hazard unit sitting beside the ID/EX register.
// Tracks dest/regwrite/memread for the EX, MEM and WB stages and registers ALU operand selects.
module forwarding_control_unit
   import forwarding_control_unit_pkg::*;
#(
   parameter int BITS_REGS          = DEFAULT_BITS_REGS,
   parameter int BITS_CORTOCIRCUITO = DEFAULT_BITS_CORTOCIRCUITO
) (
   input logic                     i_clk,
   input logic                     i_reset,
   forwarding_control_unit_if.slave bus
);

   logic [BITS_REGS-1:0]          ex_dest, mem_dest, wb_dest;
   logic                          ex_regwrite, mem_regwrite, wb_regwrite;
   logic                          ex_memread, mem_memread, wb_memread;
   logic [BITS_CORTOCIRCUITO-1:0] sel_a_q, sel_b_q;
   logic [BITS_CORTOCIRCUITO-1:0] sel_a_next, sel_b_next;
   logic                          hazard;

   forwarding_operand_select #(
      .BITS_REGS          (BITS_REGS),
      .BITS_CORTOCIRCUITO (BITS_CORTOCIRCUITO)
   ) u_select_a (
      .operand      (bus.i_id_rs),
      .ex_dest      (ex_dest),
      .ex_regwrite  (ex_regwrite),
      .mem_dest     (mem_dest),
      .mem_regwrite (mem_regwrite),
      .sel          (sel_a_next)
   );

   forwarding_operand_select #(
      .BITS_REGS          (BITS_REGS),
      .BITS_CORTOCIRCUITO (BITS_CORTOCIRCUITO)
   ) u_select_b (
      .operand      (bus.i_id_rt),
      .ex_dest      (ex_dest),
      .ex_regwrite  (ex_regwrite),
      .mem_dest     (mem_dest),
      .mem_regwrite (mem_regwrite),
      .sel          (sel_b_next)
   );

   // A load in EX whose result the ID instruction needs cannot be forwarded in time.
   assign hazard = ex_memread && ex_regwrite && (ex_dest != '0) &&
                   ((ex_dest == bus.i_id_rs) || (ex_dest == bus.i_id_rt));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ex_dest      <= '0;
         ex_regwrite  <= 1'b0;
         ex_memread   <= 1'b0;
         mem_dest     <= '0;
         mem_regwrite <= 1'b0;
         mem_memread  <= 1'b0;
         wb_dest      <= '0;
         wb_regwrite  <= 1'b0;
         wb_memread   <= 1'b0;
         sel_a_q      <= BITS_CORTOCIRCUITO'(FWD_IDEX);
         sel_b_q      <= BITS_CORTOCIRCUITO'(FWD_IDEX);
      end else if (bus.i_pipe_en) begin
         wb_dest      <= mem_dest;
         wb_regwrite  <= mem_regwrite;
         wb_memread   <= mem_memread;
         mem_dest     <= ex_dest;
         mem_regwrite <= ex_regwrite;
         mem_memread  <= ex_memread;
         if (hazard) begin
            ex_dest     <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            sel_a_q     <= BITS_CORTOCIRCUITO'(FWD_IDEX);
            sel_b_q     <= BITS_CORTOCIRCUITO'(FWD_IDEX);
         end else begin
            ex_dest     <= bus.i_id_dest;
            ex_regwrite <= bus.i_id_regwrite;
            ex_memread  <= bus.i_id_memread;
            sel_a_q     <= sel_a_next;
            sel_b_q     <= sel_b_next;
         end
      end
   end

   assign bus.o_corto_register_A = sel_a_q;
   assign bus.o_corto_register_B = sel_b_q;
   assign bus.o_stall            = hazard && bus.i_pipe_en;
   assign bus.o_flush_idex       = hazard && bus.i_pipe_en;
   assign bus.shadow_ex          = {ex_dest, ex_regwrite, ex_memread};
   assign bus.shadow_mem         = {mem_dest, mem_regwrite, mem_memread};
   assign bus.shadow_wb          = {wb_dest, wb_regwrite, wb_memread};

endmodule

// File: tb/tb_forwarding_control_unit.sv
// Self-checking bench for forwarding_control_unit: directed MIPS instruction sequences,
// a stage-array reference model checked every cycle, and literal expectations for key steps.
module tb_forwarding_control_unit;

   logic clk;
   logic reset;
   bit   checking;
   int   checks;
   int   errors;

   forwarding_control_unit_if bus ();

   forwarding_control_unit dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: index 0 = EX, 1 = MEM, 2 = WB.
   logic [4:0] m_dest [3] = '{default: 5'd0};
   bit         m_rw   [3] = '{default: 1'b0};
   bit         m_mr   [3] = '{default: 1'b0};
   logic [2:0] m_sel_a = 3'b000;
   logic [2:0] m_sel_b = 3'b000;

   function automatic bit modelHazard();
      return m_mr[0] && m_rw[0] && (m_dest[0] != 5'd0) &&
             ((m_dest[0] == bus.i_id_rs) || (m_dest[0] == bus.i_id_rt));
   endfunction

   // Newest producer first: EX slot gives code 1, MEM slot gives code 2.
   function automatic logic [2:0] modelForward(input logic [4:0] x);
      for (int s = 0; s < 2; s++) begin
         if (m_rw[s] && (m_dest[s] != 5'd0) && (m_dest[s] == x)) return 3'(s + 1);
      end
      return 3'b000;
   endfunction

   function automatic logic [6:0] modelSlot(input int s);
      return {m_dest[s], m_rw[s], m_mr[s]};
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_dest  <= '{default: 5'd0};
         m_rw    <= '{default: 1'b0};
         m_mr    <= '{default: 1'b0};
         m_sel_a <= 3'b000;
         m_sel_b <= 3'b000;
      end else if (bus.i_pipe_en) begin
         m_dest[2] <= m_dest[1];
         m_rw[2]   <= m_rw[1];
         m_mr[2]   <= m_mr[1];
         m_dest[1] <= m_dest[0];
         m_rw[1]   <= m_rw[0];
         m_mr[1]   <= m_mr[0];
         if (modelHazard()) begin
            m_dest[0] <= 5'd0;
            m_rw[0]   <= 1'b0;
            m_mr[0]   <= 1'b0;
            m_sel_a   <= 3'b000;
            m_sel_b   <= 3'b000;
         end else begin
            m_dest[0] <= bus.i_id_dest;
            m_rw[0]   <= bus.i_id_regwrite;
            m_mr[0]   <= bus.i_id_memread;
            m_sel_a   <= modelForward(bus.i_id_rs);
            m_sel_b   <= modelForward(bus.i_id_rt);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model, mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("model_sel_A", 32'(bus.o_corto_register_A), 32'(m_sel_a));
         checkOutput("model_sel_B", 32'(bus.o_corto_register_B), 32'(m_sel_b));
         checkOutput("model_stall", 32'(bus.o_stall), 32'(modelHazard() && bus.i_pipe_en));
         checkOutput("model_flush", 32'(bus.o_flush_idex), 32'(modelHazard() && bus.i_pipe_en));
         checkOutput("model_ex", 32'(bus.shadow_ex), 32'(modelSlot(0)));
         checkOutput("model_mem", 32'(bus.shadow_mem), 32'(modelSlot(1)));
         checkOutput("model_wb", 32'(bus.shadow_wb), 32'(modelSlot(2)));
      end
   end

   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                                input logic rw, input logic mr, input logic en, input logic rst);
      bus.i_id_rs       = rs;
      bus.i_id_rt       = rt;
      bus.i_id_dest     = dest;
      bus.i_id_regwrite = rw;
      bus.i_id_memread  = mr;
      bus.i_pipe_en     = en;
      reset             = rst;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic nop();
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      checking = 1'b0;

      // Reset with arbitrary ID inputs
      applyStimulus(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
      tick();
      checking = 1'b1;
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("reset_A", 32'(bus.o_corto_register_A), 32'h0);
      checkOutput("reset_B", 32'(bus.o_corto_register_B), 32'h0);
      checkOutput("reset_stall", 32'(bus.o_stall), 32'h0);
      checkOutput("reset_slots", 32'({bus.shadow_ex, bus.shadow_mem, bus.shadow_wb}), 32'h0);

      // add $3,$1,$2 ; sub $4,$3,$5
      applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      applyStimulus(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      checkOutput("exmem_A", 32'(bus.o_corto_register_A), 32'h1);
      checkOutput("exmem_B", 32'(bus.o_corto_register_B), 32'h0);

      // add $3 ; nop ; or $6,$7,$3
      nop(); nop();
      applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      nop();
      applyStimulus(5'd7, 5'd3, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      checkOutput("memwb_A", 32'(bus.o_corto_register_A), 32'h0);
      checkOutput("memwb_B", 32'(bus.o_corto_register_B), 32'h2);

      // add $3 ; add $3 ; and $8,$3,$3
      nop(); nop();
      applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      applyStimulus(5'd3, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      checkOutput("prio_A", 32'(bus.o_corto_register_A), 32'h1);
      checkOutput("prio_B", 32'(bus.o_corto_register_B), 32'h1);

      // addi $0,$0,5 ; add $9,$0,$0
      nop(); nop();
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      applyStimulus(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      checkOutput("zero_A", 32'(bus.o_corto_register_A), 32'h0);
      checkOutput("zero_B", 32'(bus.o_corto_register_B), 32'h0);

      // lw $2,0($1) ; add $4,$2,$2
      nop(); nop();
      applyStimulus(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
      applyStimulus(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("lu_stall", 32'(bus.o_stall), 32'h1);
      checkOutput("lu_flush", 32'(bus.o_flush_idex), 32'h1);
      tick();
      checkOutput("lu_bubble_A", 32'(bus.o_corto_register_A), 32'h0);
      checkOutput("lu_bubble_ex", 32'(bus.shadow_ex), 32'h0);
      applyStimulus(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("lu_retry_stall", 32'(bus.o_stall), 32'h0);
      tick();
      checkOutput("lu_retry_A", 32'(bus.o_corto_register_A), 32'h2);
      checkOutput("lu_retry_B", 32'(bus.o_corto_register_B), 32'h2);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lu_after_stall", 32'(bus.o_stall), 32'h0);
      tick();

      // Pending hazard while the pipeline is frozen
      nop(); nop();
      applyStimulus(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
         checkOutput("frz_stall", 32'(bus.o_stall), 32'h0);
         tick();
         checkOutput("frz_ex", 32'(bus.shadow_ex), 32'({5'd2, 1'b1, 1'b1}));
      end
      applyStimulus(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("frz_resume_stall", 32'(bus.o_stall), 32'h1);
      tick();
      applyStimulus(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      checkOutput("frz_resume_A", 32'(bus.o_corto_register_A), 32'h2);

      // Reset mid-stream with the pipeline enabled
      applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      applyStimulus(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1); tick();
      checkOutput("mid_reset_slots", 32'({bus.shadow_ex, bus.shadow_mem, bus.shadow_wb}), 32'h0);
      checkOutput("mid_reset_A", 32'(bus.o_corto_register_A), 32'h0);
      applyStimulus(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      checkOutput("post_reset_A", 32'(bus.o_corto_register_A), 32'h0);

      // Random traffic over a small register range to hit overlaps often
      for (int i = 0; i < 200; i++) begin
         applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
         tick();
      end

      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
